// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 registered mux.
// Imported by the scan sequencer and the mux top.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_nx1_scan_seq.sv
// Auto-scan channel sequencer for the N:1 mux.
// Steps ch through 0..N_CH-1, DWELL accepted samples each.
module scan_seq
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int DWELL = 1,
  localparam int CW    = clog2_min1(N_CH),
  localparam int DWW   = clog2_min1(DWELL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] ch
);

  localparam logic [CW-1:0]  CH_LAST = CW'(N_CH - 1);
  localparam logic [DWW-1:0] DW_LAST = DWW'(DWELL - 1);

  logic [DWW-1:0] dw_cnt;
  logic [CW-1:0]  ch_base;
  logic [DWW-1:0] dw_base;
  logic           dw_done;
  logic [CW-1:0]  ch_next;

  // A mode change restarts from channel 0 in the same cycle,
  // so a sample on that cycle counts against the fresh state.
  always_comb begin
    ch_base = clr ? '0 : ch;
    dw_base = clr ? '0 : dw_cnt;
    dw_done = (dw_base == DW_LAST);
    ch_next = (ch_base == CH_LAST) ? '0 : ch_base + 1'b1;
  end

  // Counters advance only on accepted scan samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch     <= '0;
      dw_cnt <= '0;
    end else if (en) begin
      if (dw_done) begin
        dw_cnt <= '0;
        ch     <= ch_next;
      end else begin
        dw_cnt <= dw_base + 1'b1;
        ch     <= ch_base;
      end
    end else if (clr) begin
      ch     <= '0;
      dw_cnt <= '0;
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N-channel, W-bit mux with valid, channel tag,
// out-of-range select flag and an auto-scan mode.
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 1,
  localparam int CW    = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [CW-1:0]   sel,
  input  logic [N_CH*W-1:0] in_bus,
  input  logic            in_valid,
  output logic [W-1:0]    y,
  output logic            y_valid,
  output logic [CW-1:0]   y_ch,
  output logic            sel_err
);

  localparam int NPOW = 1 << CW;

  logic [W-1:0]  lane [NPOW];
  logic          mode_q;
  logic          mode_chg;
  logic          scan;
  logic          seq_en;
  logic          sel_ok;
  logic [CW-1:0] seq_ch;
  logic [CW-1:0] scan_ch;

  // Unpack the bus; unused select codes map to zero lanes.
  for (genvar k = 0; k < NPOW; k++) begin : g_lane
    if (k < N_CH) begin : g_used
      assign lane[k] = in_bus[k*W +: W];
    end else begin : g_pad
      assign lane[k] = '0;
    end
  end

  // Only non-power-of-2 channel counts can see a bad select.
  if (NPOW == N_CH) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_chk
    assign sel_ok = (sel <= CW'(N_CH - 1));
  end

  // Decode mode and pick the scan channel for this cycle.
  always_comb begin
    scan     = (mode == MODE_SCAN);
    mode_chg = (mode != mode_q);
    seq_en   = in_valid & scan;
    scan_ch  = mode_chg ? '0 : seq_ch;
  end

  scan_seq #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_seq (
    .clk (clk),
    .rst (rst),
    .en  (seq_en),
    .clr (mode_chg),
    .ch  (seq_ch)
  );

  // Output register: one-cycle latency, valid and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_ch    <= '0;
      sel_err <= 1'b0;
      mode_q  <= MODE_MANUAL;
    end else begin
      mode_q  <= mode;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
      if (in_valid) begin
        if (scan) begin
          y       <= lane[scan_ch];
          y_ch    <= scan_ch;
          y_valid <= 1'b1;
        end else if (sel_ok) begin
          y       <= lane[sel];
          y_ch    <= sel;
          y_valid <= 1'b1;
        end else begin
          sel_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: directed table plus random regression
// over several channel counts, widths and dwell settings.
module tb_mux_nx1_scan;
  import mux_pkg::*;

  localparam int NI = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [2:0]  sel;
  logic [63:0] bus;

  always #5 clk = ~clk;

  logic       d4_y, d4_yv, d4_err;
  logic [1:0] d4_ych;
  logic       e4_y, e4_yv, e4_err;
  logic [1:0] e4_ych;
  logic [7:0] d3_y;
  logic       d3_yv, d3_err;
  logic [1:0] d3_ych;
  logic       r2_y, r2_yv, r2_err;
  logic [0:0] r2_ych;
  logic [7:0] r5_y;
  logic       r5_yv, r5_err;
  logic [2:0] r5_ych;
  logic       r8_y, r8_yv, r8_err;
  logic [2:0] r8_ych;

  mux_nx1_scan #(.N_CH(4), .W(1), .DWELL(1)) u_d4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel[1:0]),
    .in_bus(bus[3:0]), .in_valid(in_valid), .y(d4_y),
    .y_valid(d4_yv), .y_ch(d4_ych), .sel_err(d4_err));

  mux_nx1_scan #(.N_CH(4), .W(1), .DWELL(3)) u_e4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel[1:0]),
    .in_bus(bus[3:0]), .in_valid(in_valid), .y(e4_y),
    .y_valid(e4_yv), .y_ch(e4_ych), .sel_err(e4_err));

  mux_nx1_scan #(.N_CH(3), .W(8), .DWELL(1)) u_d3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel[1:0]),
    .in_bus(bus[23:0]), .in_valid(in_valid), .y(d3_y),
    .y_valid(d3_yv), .y_ch(d3_ych), .sel_err(d3_err));

  mux_nx1_scan #(.N_CH(2), .W(1), .DWELL(1)) u_r2 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel[0:0]),
    .in_bus(bus[1:0]), .in_valid(in_valid), .y(r2_y),
    .y_valid(r2_yv), .y_ch(r2_ych), .sel_err(r2_err));

  mux_nx1_scan #(.N_CH(5), .W(8), .DWELL(3)) u_r5 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_bus(bus[39:0]), .in_valid(in_valid), .y(r5_y),
    .y_valid(r5_yv), .y_ch(r5_ych), .sel_err(r5_err));

  mux_nx1_scan #(.N_CH(8), .W(1), .DWELL(2)) u_r8 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_bus(bus[7:0]), .in_valid(in_valid), .y(r8_y),
    .y_valid(r8_yv), .y_ch(r8_ych), .sel_err(r8_err));

  logic [7:0] dy   [NI];
  logic       dyv  [NI];
  logic       derr [NI];
  int         dch  [NI];

  assign dy[0] = {7'b0, d4_y};
  assign dy[1] = {7'b0, e4_y};
  assign dy[2] = d3_y;
  assign dy[3] = {7'b0, r2_y};
  assign dy[4] = r5_y;
  assign dy[5] = {7'b0, r8_y};
  assign dyv[0] = d4_yv;
  assign dyv[1] = e4_yv;
  assign dyv[2] = d3_yv;
  assign dyv[3] = r2_yv;
  assign dyv[4] = r5_yv;
  assign dyv[5] = r8_yv;
  assign derr[0] = d4_err;
  assign derr[1] = e4_err;
  assign derr[2] = d3_err;
  assign derr[3] = r2_err;
  assign derr[4] = r5_err;
  assign derr[5] = r8_err;
  assign dch[0] = int'(d4_ych);
  assign dch[1] = int'(e4_ych);
  assign dch[2] = int'(d3_ych);
  assign dch[3] = int'(r2_ych);
  assign dch[4] = int'(r5_ych);
  assign dch[5] = int'(r8_ych);

  function automatic int p_n(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 3;
      3: return 2;
      4: return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int p_w(input int i);
    return (i == 2 || i == 4) ? 8 : 1;
  endfunction

  function automatic int p_d(input int i);
    case (i)
      1: return 3;
      4: return 3;
      5: return 2;
      default: return 1;
    endcase
  endfunction

  typedef struct {
    logic [7:0] y;
    logic       yv;
    int         ych;
    logic       err;
    int         ch;
    int         dw;
    logic       mq;
  } mstate_t;

  mstate_t ms [NI];

  function automatic logic [7:0] pick(input logic [63:0] b,
                                      input int c, input int w);
    logic [63:0] t;
    t = b >> (c * w);
    return (w == 8) ? t[7:0] : {7'b0, t[0]};
  endfunction

  // Reference: one clock of the mux for instance i.
  function automatic mstate_t mstep(input mstate_t s, input int i,
                                    input logic r, input logic md,
                                    input int sl0, input logic iv,
                                    input logic [63:0] b);
    mstate_t o;
    int n, w, dl, c, d, sl;
    n  = p_n(i);
    w  = p_w(i);
    dl = p_d(i);
    sl = sl0 & ((1 << clog2_min1(n)) - 1);
    o = s;
    o.yv  = 1'b0;
    o.err = 1'b0;
    if (r) begin
      o.y = '0; o.ych = 0; o.ch = 0; o.dw = 0; o.mq = 1'b0;
      return o;
    end
    c = (md != s.mq) ? 0 : s.ch;
    d = (md != s.mq) ? 0 : s.dw;
    o.mq = md;
    if (iv) begin
      if (md == MODE_MANUAL) begin
        if (sl < n) begin
          o.y = pick(b, sl, w); o.ych = sl; o.yv = 1'b1;
        end else begin
          o.err = 1'b1;
        end
      end else begin
        o.y = pick(b, c, w); o.ych = c; o.yv = 1'b1;
        if (d == dl - 1) begin
          d = 0;
          c = (c == n - 1) ? 0 : c + 1;
        end else begin
          d = d + 1;
        end
      end
    end
    o.ch = c;
    o.dw = d;
    return o;
  endfunction

  int n_pass = 0;
  int n_chk  = 0;
  int pow2_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < NI; i++)
      ms[i] = mstep(ms[i], i, rst, mode, int'(sel), in_valid, bus);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        mode;
    logic [2:0]  sel;
    logic        iv;
    logic [63:0] bus;
    int          idx;
    logic [7:0]  ey;
    logic        eyv;
    int          ech;
    logic        eerr;
  } vec_t;

  vec_t tv [$];

  function automatic vec_t mk(input logic r, input logic md,
                              input int s, input logic iv,
                              input logic [63:0] b, input int idx,
                              input logic [7:0] ey, input logic eyv,
                              input int ech, input logic eerr);
    vec_t v;
    v.rst = r; v.mode = md; v.sel = 3'(s); v.iv = iv; v.bus = b;
    v.idx = idx; v.ey = ey; v.eyv = eyv; v.ech = ech; v.eerr = eerr;
    return v;
  endfunction

  localparam logic [63:0] B5 = 64'h5;
  localparam logic [63:0] B3 = 64'hCCBBAA;

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; sel = '0; bus = '0;

    // 4:1 manual, then reset mid-stream
    tv.push_back(mk(1, 0, 0, 0, B5, 0, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 0, 0, 1, B5, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 1, B5, 0, 8'h00, 1, 1, 0));
    tv.push_back(mk(0, 0, 2, 1, B5, 0, 8'h01, 1, 2, 0));
    tv.push_back(mk(0, 0, 3, 1, B5, 0, 8'h00, 1, 3, 0));
    tv.push_back(mk(1, 0, 0, 1, B5, 0, 8'h00, 0, 0, 0));
    // 4:1 scan, dwell 1, wrap
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h00, 1, 1, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h01, 1, 2, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h00, 1, 3, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 0, 8'h00, 1, 1, 0));
    // 4:1 scan, dwell 3, gaps in valid
    tv.push_back(mk(1, 0, 0, 0, B5, 1, 8'h00, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 1, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, B5, 1, 8'h01, 0, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 1, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 1, 8'h01, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B5, 1, 8'h00, 1, 1, 0));
    // 3:1 x8 manual with bad select
    tv.push_back(mk(0, 0, 2, 1, B3, 2, 8'hCC, 1, 2, 0));
    tv.push_back(mk(0, 0, 3, 1, B3, 2, 8'hCC, 0, 2, 1));
    tv.push_back(mk(0, 0, 0, 1, B3, 2, 8'hAA, 1, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, B3, 2, 8'hAA, 0, 0, 0));
    // 3:1 scan to ch 2, manual detour, back to scan
    tv.push_back(mk(0, 1, 0, 1, B3, 2, 8'hAA, 1, 0, 0));
    tv.push_back(mk(0, 1, 0, 1, B3, 2, 8'hBB, 1, 1, 0));
    tv.push_back(mk(0, 0, 1, 1, B3, 2, 8'hBB, 1, 1, 0));
    tv.push_back(mk(0, 1, 0, 1, B3, 2, 8'hAA, 1, 0, 0));

    foreach (tv[k]) begin
      rst = tv[k].rst; mode = tv[k].mode; sel = tv[k].sel;
      in_valid = tv[k].iv; bus = tv[k].bus;
      cyc();
      chk($sformatf("v%0d y", k), int'(dy[tv[k].idx]), int'(tv[k].ey));
      chk($sformatf("v%0d y_valid", k), int'(dyv[tv[k].idx]),
          int'(tv[k].eyv));
      chk($sformatf("v%0d y_ch", k), dch[tv[k].idx], tv[k].ech);
      chk($sformatf("v%0d sel_err", k), int'(derr[tv[k].idx]),
          int'(tv[k].eerr));
    end

    rst = 1'b1; in_valid = 1'b0;
    cyc();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel = 3'($urandom_range(0, 7));
      in_valid = ($urandom_range(0, 9) < 7);
      bus = {$urandom, $urandom};
      cyc();
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("rand c%0d i%0d", c, i),
            {dy[i], 7'b0, dyv[i], dch[i][7:0], 7'b0, derr[i]},
            {ms[i].y, 7'b0, ms[i].yv, ms[i].ych[7:0], 7'b0, ms[i].err});
      end
      if (d4_err | e4_err | r2_err | r8_err) pow2_err++;
    end
    chk("pow2 sel_err", pow2_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N-channel, W-bit multiplexer. Generalises the team's 4:1 single-bit mux primitive to arbitrary channel count and width.
- Adds an output register with a valid qualifier, a channel tag and out-of-range select detection.
- Adds an auto-scan mode: an internal channel sequencer steps through all inputs with a programmable dwell.
- Sits between sampled multi-channel sources and a single-lane consumer (monitor, serialiser, debug bus).

Parameters:
- N_CH, 4, number of input channels (>=2).
- W, 1, bits per channel.
- DWELL, 1, accepted samples per channel in scan mode before advancing (>=1).
- CW, $clog2(N_CH), select/channel-index width. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual select, 1 = auto-scan.
- sel  input  CW  manual channel select. Ignored in scan mode.
- in_bus  input  N_CH*W  channel k occupies bits [k*W +: W].
- in_valid  input  1  in_bus is valid this cycle.
- y  output  W  registered selected data.
- y_valid  output  1  y holds a new sample this cycle (1-cycle pulse per accepted sample).
- y_ch  output  CW  channel index that produced y.
- sel_err  output  1  1-cycle pulse: manual select was out of range.

Behaviour:
- Reset (rst=1 at a clk edge):
  - y=0, y_valid=0, y_ch=0, sel_err=0.
  - Scan channel counter ch_cnt=0, dwell counter dw_cnt=0, registered mode copy mode_q=0.
  - Reset mid-stream discards any sample presented in that cycle.
- Latency: exactly 1 cycle. A sample accepted at edge n appears on y/y_valid/y_ch after edge n.
- When no sample is accepted: y and y_ch hold, y_valid=0.
- Manual mode (mode=1'b0), per edge with in_valid=1:
  - If sel<N_CH: y<=in_bus[sel*W +: W], y_ch<=sel, y_valid<=1, sel_err<=0.
  - If sel>=N_CH (only possible when N_CH is not a power of 2): y and y_ch hold, y_valid<=0, sel_err<=1.
  - in_valid=0 -> y_valid<=0, sel_err<=0.
- Scan mode (mode=1'b1), FSM state is {ch_cnt, dw_cnt}, per edge with in_valid=1:
  - y<=in_bus[ch_cnt*W +: W], y_ch<=ch_cnt, y_valid<=1.
  - If dw_cnt==DWELL-1: dw_cnt<=0 and ch_cnt advances, wrapping N_CH-1 -> 0.
  - Otherwise dw_cnt<=dw_cnt+1.
  - in_valid=0 -> counters hold, y_valid<=0.
  - sel_err is always 0 in scan mode.
- Mode change (mode != mode_q):
  - ch_cnt<=0 and dw_cnt<=0.
  - A sample presented on the switching cycle is processed under the new mode:
    - Manual uses sel.
    - Scan uses channel 0 and counts as the first dwell sample, so dw_cnt<=1, or the channel advances if DWELL==1.
  - mode_q<=mode every cycle.
- Width rules:
  - Counters are sized CW and $clog2(DWELL+1).
  - No arithmetic overflow: wrap is by explicit compare to N_CH-1, never by natural roll-over. This is required for non-power-of-2 N_CH.
- No combinational path from any input to any output.

Decomposition:
- Shared package mux_pkg holds:
  - Function clog2_min1(n), returning max(1,$clog2(n)).
  - Mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
- One natural sub-module: scan_seq, the ch_cnt/dw_cnt sequencer. Inputs clk, rst, en (in_valid & scan), clr (mode change); output ch.
- The data path stays in the top module.

Test Plan:
- N_CH=4, W=1, reset, then manual, in_bus=4'h5, in_valid=1, sel=0,1,2,3 on consecutive cycles -> one cycle later y=1,0,1,0, y_ch=0,1,2,3, y_valid=1 each cycle. Assert rst mid-sequence -> next cycle y=0, y_valid=0.
- N_CH=4, W=1, DWELL=1, scan, in_bus=4'h5, in_valid=1 for 6 cycles -> y_ch=0,1,2,3,0,1, y=1,0,1,0,1,0 (wrap verified).
- N_CH=4, DWELL=3, scan, in_valid toggled 1,0,1,1,1 -> y_valid=1,0,1,1,1. y_ch=0,-,0,0,1 (channel advances only on accepted samples).
- N_CH=3, W=8, manual, in_bus={8'hCC,8'hBB,8'hAA}:
  - sel=2 -> y=8'hCC.
  - sel=3 -> sel_err=1, y_valid=0, y holds 8'hCC.
  - sel=0 -> y=8'hAA, sel_err=0.
- N_CH=3, W=8, scan running at ch_cnt=2. Switch mode to manual with sel=1, then back to scan -> first scan sample after return has y_ch=0, y=8'hAA.
- Random regression, N_CH in {2,3,5,8}, W in {1,8}: random mode/sel/in_valid/in_bus checked against a 1-cycle reference model. Confirm sel_err never fires when N_CH is a power of 2.
